// File: rtl/kbd_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : kbd_event_ctrl
// Brief    : Drains ps2_keyboard bytes, folds E0/F0 prefixes into key events,
//            tracks modifiers, buffers events in a FIFO and counts key presses.
// Revision : 1.0
// ============================================================================
module kbd_event_ctrl #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             kb_ready,
  input  logic [7:0]       kb_data,
  input  logic             kb_overflow,
  output logic             nextdata_n,
  output logic             evt_valid,
  output logic [7:0]       evt_code,
  output logic             evt_ext,
  output logic             evt_break,
  input  logic             evt_pop,
  output logic             evt_drop,
  output logic             ovf_err,
  output logic             shift,
  output logic             ctrl,
  output logic             caps,
  output logic             upper,
  output logic [CNT_W-1:0] press_count
);

  localparam int                c_ADDR_W = $clog2(FIFO_DEPTH);
  localparam logic [c_ADDR_W:0] c_FULL   = (c_ADDR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACK    = 2'd1,
    S_SETTLE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic                w_nextdata_n_next;
  logic                r_nextdata_n;
  logic [7:0]          r_byte;
  logic                r_ext_f;
  logic                r_brk_f;
  logic [9:0]          r_mem [FIFO_DEPTH];
  logic [c_ADDR_W-1:0] r_wr_ptr;
  logic [c_ADDR_W-1:0] r_rd_ptr;
  logic [c_ADDR_W:0]   r_count;
  logic                r_evt_drop;
  logic                r_ovf;
  logic                r_lshift;
  logic                r_rshift;
  logic                r_lctrl;
  logic                r_rctrl;
  logic                r_caps;
  logic                r_caps_held;
  logic [CNT_W-1:0]    r_press_count;

  logic w_in_ack;
  logic w_emit;
  logic w_full;
  logic w_pop;
  logic w_push;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state      <= S_IDLE;
      r_nextdata_n <= 1'b1;
      r_byte       <= 8'h00;
    end else begin
      r_state      <= w_state_next;
      r_nextdata_n <= w_nextdata_n_next;
      if (r_state == S_IDLE && kb_ready) r_byte <= kb_data;
    end
  end

  // The pop strobe is registered, so it is requested on the IDLE->ACK transition.
  always_comb begin
    w_state_next      = r_state;
    w_nextdata_n_next = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (kb_ready) begin
          w_state_next      = S_ACK;
          w_nextdata_n_next = 1'b0;
        end
      end
      S_ACK:    w_state_next = S_SETTLE;
      S_SETTLE: w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  assign w_in_ack = (r_state == S_ACK);
  assign w_emit   = w_in_ack && (r_byte != 8'hE0) && (r_byte != 8'hF0);
  assign w_full   = (r_count == c_FULL);
  assign w_pop    = evt_pop && (r_count != '0);
  assign w_push   = w_emit && (!w_full || w_pop);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_ext_f <= 1'b0;
      r_brk_f <= 1'b0;
    end else if (w_in_ack) begin
      if (r_byte == 8'hE0) begin
        r_ext_f <= 1'b1;
      end else if (r_byte == 8'hF0) begin
        r_brk_f <= 1'b1;
      end else begin
        r_ext_f <= 1'b0;
        r_brk_f <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {r_ext_f, r_brk_f, r_byte};
  end

  // A full FIFO still accepts a push when the consumer pops in the same cycle.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_evt_drop <= 1'b0;
    end else begin
      r_evt_drop <= w_emit && w_full && !w_pop;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_lshift      <= 1'b0;
      r_rshift      <= 1'b0;
      r_lctrl       <= 1'b0;
      r_rctrl       <= 1'b0;
      r_caps        <= 1'b0;
      r_caps_held   <= 1'b0;
      r_press_count <= '0;
      r_ovf         <= 1'b0;
    end else begin
      if (kb_overflow) r_ovf <= 1'b1;
      if (w_emit) begin
        if (!r_brk_f) r_press_count <= r_press_count + 1'b1;
        if (r_byte == 8'h12 && !r_ext_f) r_lshift <= !r_brk_f;
        if (r_byte == 8'h59) r_rshift <= !r_brk_f;
        if (r_byte == 8'h14) begin
          if (r_ext_f) r_rctrl <= !r_brk_f;
          else         r_lctrl <= !r_brk_f;
        end
        // caps_held suppresses re-toggling on typematic repeats of the make code.
        if (r_byte == 8'h58) begin
          if (r_brk_f) begin
            r_caps_held <= 1'b0;
          end else begin
            if (!r_caps_held) r_caps <= ~r_caps;
            r_caps_held <= 1'b1;
          end
        end
      end
    end
  end

  assign nextdata_n                      = r_nextdata_n;
  assign evt_valid                       = (r_count != '0);
  assign {evt_ext, evt_break, evt_code}  = r_mem[r_rd_ptr];
  assign evt_drop                        = r_evt_drop;
  assign ovf_err                         = r_ovf;
  assign shift                           = r_lshift | r_rshift;
  assign ctrl                            = r_lctrl | r_rctrl;
  assign caps                            = r_caps;
  assign upper                           = r_caps ^ (r_lshift | r_rshift);
  assign press_count                     = r_press_count;

endmodule
`default_nettype wire
